// File: rtl/dca_neugemm_store_row_buffer.sv
// Result-row staging buffer: captures one matrix row by row from the NeuGEMM core,
// then replays the rows in order to the LSU store-row handshake.
module dca_neugemm_store_row_buffer #(
  parameter  int BW_TENSOR_SCALAR = 16,
  parameter  int MATRIX_NUM_COL   = 8,
  parameter  int MATRIX_NUM_ROW   = 8,
  localparam int BW_ROW           = BW_TENSOR_SCALAR * MATRIX_NUM_COL,
  localparam int BW_CNT           = $clog2(MATRIX_NUM_ROW + 1)
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              clear,
  input  logic              result_row_wvalid,
  input  logic              result_row_wlast,
  input  logic [BW_ROW-1:0] result_row_wdata,
  output logic              result_row_wready,
  input  logic              sstore_tensor_row_rvalid,
  input  logic              sstore_tensor_row_rlast,
  output logic              sstore_tensor_row_rready,
  output logic [BW_ROW-1:0] sstore_tensor_row_rdata,
  output logic [BW_CNT-1:0] row_count,
  output logic              matrix_ready,
  output logic              error
);

  localparam int PTR_W = (MATRIX_NUM_ROW > 1) ? $clog2(MATRIX_NUM_ROW) : 1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [BW_CNT-1:0]  r_count;
  logic               r_error;
  logic [BW_ROW-1:0]  r_mem [MATRIX_NUM_ROW];

  logic w_full;
  logic w_empty;
  logic w_wr_fire;
  logic w_rd_fire;
  logic w_pop;
  logic w_underflow;
  logic w_mismatch;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MATRIX_NUM_ROW - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full      = (r_count == BW_CNT'(MATRIX_NUM_ROW));
  assign w_empty     = (r_count == '0);
  assign w_wr_fire   = (r_state == ST_FILL) && result_row_wvalid && !w_full;
  assign w_rd_fire   = (r_state == ST_DRAIN) && sstore_tensor_row_rvalid;
  assign w_pop       = w_rd_fire && !w_empty;
  assign w_underflow = w_rd_fire && w_empty;
  // rlast while more than the popped row is still held: the LSU asked for fewer rows.
  assign w_mismatch  = w_rd_fire && sstore_tensor_row_rlast && (r_count > BW_CNT'(1));

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next             = r_state;
    result_row_wready        = 1'b0;
    sstore_tensor_row_rready = 1'b0;
    sstore_tensor_row_rdata  = '0;
    case (r_state)
      ST_FILL: begin
        result_row_wready = !w_full;
        if (w_wr_fire &&
            (result_row_wlast || (r_count == BW_CNT'(MATRIX_NUM_ROW - 1)))) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        sstore_tensor_row_rready = sstore_tensor_row_rvalid;
        if (sstore_tensor_row_rvalid && !w_empty) begin
          sstore_tensor_row_rdata = r_mem[r_rd_ptr];
        end
        if (w_rd_fire && sstore_tensor_row_rlast) begin
          w_state_next = ST_FILL;
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rstnn || clear) begin
      r_state  <= ST_FILL;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_wr_fire) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
        r_count  <= r_count + BW_CNT'(1);
      end
      if (w_mismatch) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_count  <= r_count - BW_CNT'(1);
      end
      if (w_underflow || w_mismatch) begin
        r_error <= 1'b1;
      end
    end
  end

  // NOTE: the row storage is deliberately not reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr] <= result_row_wdata;
    end
  end

  assign row_count    = r_count;
  assign matrix_ready = (r_state == ST_DRAIN);
  assign error        = r_error;

endmodule
